// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory port.
// Holds a 2^ADDR_W byte little-endian store and serves one RV32I load or
// store at a time, answering with a single-cycle rsp_valid pulse LAT cycles
// after the request is accepted.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no transaction in flight, ready for a request
//   S_BUSY | latency countdown; commit happens on the edge leaving cnt==0
//   S_RESP | rsp_valid pulse; a new request may be accepted this cycle
//
// LAT=1 spends a single cycle in S_BUSY so every latency follows the same
// "accepted at edge k, response after edge k+LAT" rule and the commit always
// works from the latched request.
module dmem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;

    logic              r_wr, r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [DATA_W-1:0] r_wr_data;

    logic [7:0]        r_mem [2**ADDR_W];

    logic              w_accept, w_commit;
    logic              w_is_h, w_is_w, w_f3_ok, w_misalign, w_err;
    logic [ADDR_W-1:0] w_a1, w_a2, w_a3;
    logic [7:0]        w_b0, w_b1, w_b2, w_b3;
    logic [DATA_W-1:0] w_load;

    assign req_ready = (r_state != S_BUSY);
    assign rsp_valid = (r_state == S_RESP);
    assign w_accept  = req_valid & req_ready & (wr | rd);
    assign w_commit  = (r_state == S_BUSY) && (r_cnt == 4'd0);

    // Next-state and countdown logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) w_state_nxt = S_RESP;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            S_RESP: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CNT_INIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the request at acceptance; it stays stable until the commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_addr    <= '0;
            r_funct3  <= 3'b000;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_wr      <= wr;
            r_rd      <= rd;
            r_addr    <= addr;
            r_funct3  <= funct3;
            r_wr_data <= wr_data;
        end
    end

    // Access legality: size/sign code, alignment, and conflicting wr+rd.
    assign w_is_h     = (r_funct3[1:0] == 2'b01);
    assign w_is_w     = (r_funct3[1:0] == 2'b10);
    assign w_f3_ok    = r_wr ? (r_funct3 inside {3'b000, 3'b001, 3'b010})
                             : (r_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_misalign = (w_is_h & r_addr[0]) | (w_is_w & (r_addr[1:0] != 2'b00));
    assign w_err      = (r_wr & r_rd) | ~w_f3_ok | w_misalign;

    // Aligned accesses never cross the top, so plain wrapping adds are safe.
    assign w_a1 = r_addr + ADDR_W'(1);
    assign w_a2 = r_addr + ADDR_W'(2);
    assign w_a3 = r_addr + ADDR_W'(3);
    assign w_b0 = r_mem[r_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    // Load result formatting with sign or zero extension.
    always_comb begin
        w_load = '0;
        case (r_funct3)
            3'b000:  w_load = {{24{w_b0[7]}}, w_b0};
            3'b001:  w_load = {{16{w_b1[7]}}, w_b1, w_b0};
            3'b010:  w_load = {w_b3, w_b2, w_b1, w_b0};
            3'b100:  w_load = {24'd0, w_b0};
            3'b101:  w_load = {16'd0, w_b1, w_b0};
            default: w_load = '0;
        endcase
    end

    // Response data and error, updated only at the commit edge and held after.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
            err     <= 1'b0;
        end else if (w_commit) begin
            err     <= w_err;
            rd_data <= (w_err || r_wr) ? '0 : w_load;
        end
    end

    // Store commit; reset in the same cycle aborts the write. Contents are never cleared.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && r_wr && !w_err) begin
            r_mem[r_addr] <= r_wr_data[7:0];
            if (w_is_h || w_is_w) r_mem[w_a1] <= r_wr_data[15:8];
            if (w_is_w) begin
                r_mem[w_a2] <= r_wr_data[23:16];
                r_mem[w_a3] <= r_wr_data[31:24];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random loads/stores against a byte-array
// reference model of the RV32I data-memory rules.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [2:0]  funct3;
    logic [31:0] wr_data;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rd_data;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mdl [512];

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .LAT(LAT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .wr        (wr),
        .rd        (rd),
        .addr      (addr),
        .funct3    (funct3),
        .wr_data   (wr_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rd_data   (rd_data),
        .err       (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: applies one access to the byte array, returns expected data/err.
    function automatic void model(input logic w, input logic r, input logic [8:0] a,
                                  input logic [2:0] f, input logic [31:0] d,
                                  output logic [31:0] ed, output logic ee);
        int n;
        logic legal;
        logic [31:0] v;
        n = (f[1:0] == 2'd0) ? 1 : ((f[1:0] == 2'd1) ? 2 : 4);
        if (w) legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
        else   legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
        ee = (w && r) || !legal || ((int'(a) % n) != 0);
        ed = 32'd0;
        if (ee) return;
        if (w) begin
            for (int i = 0; i < n; i++) mdl[int'(a) + i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(a) + i]) << (8 * i));
            if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            ed = v;
        end
    endfunction

    // Drive one request, hold until accepted, then count cycles to rsp_valid.
    task automatic xact(input logic w, input logic r, input logic [8:0] a, input logic [2:0] f,
                        input logic [31:0] d, output logic [31:0] od, output logic oe,
                        output int lat);
        int g;
        @(negedge clk);
        req_valid = 1'b1; wr = w; rd = r; addr = a; funct3 = f; wr_data = d;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        od = rd_data;
        oe = err;
    endtask

    task automatic run(input string tag, input logic w, input logic r, input logic [8:0] a,
                       input logic [2:0] f, input logic [31:0] d, output logic [31:0] od);
        logic [31:0] ed;
        logic ee, oe;
        int lat;
        model(w, r, a, f, d, ed, ee);
        xact(w, r, a, f, d, od, oe, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_data"}, od, ed);
        chk({tag, "_err"}, 32'(oe), 32'(ee));
    endtask

    initial begin
        logic [31:0] od, ea, eb;
        logic        ea_e, eb_e;
        logic        w, r;
        int          k;

        reset = 1'b1; req_valid = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = 9'd0; funct3 = 3'd0; wr_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp",   32'(rsp_valid), 32'd0);
        chk("rst_data",  rd_data, 32'd0);
        chk("rst_err",   32'(err), 32'd0);

        // Give every byte a known value.
        for (int i = 0; i < 512; i += 4) run("init", 1'b1, 1'b0, 9'(i), 3'b010, $urandom, od);

        run("sw10", 1'b1, 1'b0, 9'h010, 3'b010, 32'hDEAD_BEEF, od);
        @(posedge clk);
        #1;
        chk("pulse_width", 32'(rsp_valid), 32'd0);
        run("lw10", 1'b0, 1'b1, 9'h010, 3'b010, 32'd0, od);
        chk("lw10_const", od, 32'hDEAD_BEEF);
        run("sb13", 1'b1, 1'b0, 9'h013, 3'b000, 32'h0000_0080, od);
        run("lb13", 1'b0, 1'b1, 9'h013, 3'b000, 32'd0, od);
        chk("lb13_const", od, 32'hFFFF_FF80);
        run("lbu13", 1'b0, 1'b1, 9'h013, 3'b100, 32'd0, od);
        chk("lbu13_const", od, 32'h0000_0080);
        run("lw10b", 1'b0, 1'b1, 9'h010, 3'b010, 32'd0, od);
        chk("lw10b_const", od, 32'h80AD_BEEF);
        run("lh12", 1'b0, 1'b1, 9'h012, 3'b001, 32'd0, od);
        chk("lh12_const", od, 32'hFFFF_80AD);
        run("lhu12", 1'b0, 1'b1, 9'h012, 3'b101, 32'd0, od);
        chk("lhu12_const", od, 32'h0000_80AD);
        run("lh11_mis", 1'b0, 1'b1, 9'h011, 3'b001, 32'd0, od);
        run("sw12_mis", 1'b1, 1'b0, 9'h012, 3'b010, 32'h1111_1111, od);
        run("wrrd", 1'b1, 1'b1, 9'h010, 3'b010, 32'h2222_2222, od);
        run("sbu_ill", 1'b1, 1'b0, 9'h010, 3'b100, 32'hFFFF_FFFF, od);
        run("f3_011", 1'b0, 1'b1, 9'h010, 3'b011, 32'd0, od);
        run("lw10c", 1'b0, 1'b1, 9'h010, 3'b010, 32'd0, od);
        chk("lw10c_const", od, 32'h80AD_BEEF);

        // Non-request: valid with neither wr nor rd.
        @(negedge clk);
        req_valid = 1'b1; wr = 1'b0; rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("noreq_ready_rsp", {30'd0, req_ready, rsp_valid}, 32'd2);
        end
        req_valid = 1'b0;

        // Back-to-back: B held during BUSY, accepted at the edge ending RESP.
        model(1'b0, 1'b1, 9'h010, 3'b010, 32'd0, ea, ea_e);
        model(1'b0, 1'b1, 9'h100, 3'b001, 32'd0, eb, eb_e);
        @(negedge clk);
        req_valid = 1'b1; wr = 1'b0; rd = 1'b1; addr = 9'h010; funct3 = 3'b010;
        @(posedge clk);
        #1;
        addr = 9'h100; funct3 = 3'b001;
        chk("b2b_busy1", {30'd0, req_ready, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_busy2", {30'd0, req_ready, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_resp_a", {30'd0, req_ready, rsp_valid}, 32'd3);
        chk("b2b_data_a", rd_data, ea);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_b_busy1", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_b_busy2", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_resp_b", 32'(rsp_valid), 32'd1);
        chk("b2b_data_b", rd_data, eb);
        chk("b2b_err_b",  32'(err), 32'(eb_e));

        // Reset one cycle after accepting a store: aborted, nothing written.
        @(negedge clk);
        req_valid = 1'b1; wr = 1'b1; rd = 1'b0; addr = 9'h020; funct3 = 3'b010;
        wr_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready_rsp", {30'd0, req_ready, rsp_valid}, 32'd2);
        chk("mid_rst_data", rd_data, 32'd0);
        chk("mid_rst_err",  32'(err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_rsp2", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_rsp3", 32'(rsp_valid), 32'd0);
        run("lw20_after_rst", 1'b0, 1'b1, 9'h020, 3'b010, 32'd0, od);

        // Random mix of sizes, alignments, illegal codes and wr/rd combinations.
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            w = (k <= 4);
            r = (k == 0) || (k > 4);
            run("rnd", w, r, 9'($urandom_range(0, 511)), 3'($urandom_range(0, 7)), $urandom, od);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
